// File: rtl/sprite_hit_engine.sv
// Pixel hit-test engine: tests each visible pixel against a double-buffered object table,
// reports covering objects, the top-priority hit and per-frame player collisions.
module sprite_hit_engine #(
    parameter int unsigned N_OBJ  = 8,
    parameter int unsigned HW     = 10,
    parameter int unsigned VW     = 10,
    parameter int unsigned WRAP_W = 850,
    parameter int unsigned IW     = $clog2(N_OBJ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [HW-1:0]    h_cnt,
    input  logic [VW-1:0]    v_cnt,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [HW+VW-1:0] wr_loc,
    input  logic [HW+VW-1:0] wr_size,
    input  logic             wr_vis,
    output logic             out_valid,
    output logic [N_OBJ-1:0] hit_vec,
    output logic             top_hit,
    output logic [IW-1:0]    top_idx,
    output logic [N_OBJ-1:0] coll_vec,
    output logic             coll_valid
);

    localparam logic [HW:0] WrapW = (HW+1)'(WRAP_W);

    logic [HW+VW-1:0] sh_loc_q  [N_OBJ];
    logic [HW+VW-1:0] sh_size_q [N_OBJ];
    logic [N_OBJ-1:0] sh_vis_q;
    logic [HW+VW-1:0] act_loc_q  [N_OBJ];
    logic [HW+VW-1:0] act_size_q [N_OBJ];
    logic [N_OBJ-1:0] act_vis_q;

    logic [N_OBJ-1:0] hx_d, hy_d, hx_q, hy_q;
    logic             pv1_q;
    logic [N_OBJ-1:0] hit_d, hit_q;
    logic [IW-1:0]    top_idx_d, top_idx_q;
    logic             top_hit_q, out_valid_q;
    logic [N_OBJ-1:1] sticky_d, sticky_q;
    logic [N_OBJ-1:0] coll_vec_q;
    logic             coll_valid_q;

    // Shadow writes are accepted any time; the active copy only changes on frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_OBJ); i++) begin
                sh_loc_q[i]   <= '0;
                sh_size_q[i]  <= '0;
                act_loc_q[i]  <= '0;
                act_size_q[i] <= '0;
            end
            sh_vis_q  <= '0;
            act_vis_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_OBJ); i++) begin
                if (wr_en && wr_idx == IW'(i)) begin
                    sh_loc_q[i]  <= wr_loc;
                    sh_size_q[i] <= wr_size;
                    sh_vis_q[i]  <= wr_vis;
                end
                if (frame_start) begin
                    act_loc_q[i]  <= sh_loc_q[i];
                    act_size_q[i] <= sh_size_q[i];
                    act_vis_q[i]  <= sh_vis_q[i];
                end
            end
        end
    end

    // A pixel coincident with frame_start sees the table being committed on that edge.
    for (genvar i = 0; i < int'(N_OBJ); i++) begin : g_slot
        logic [HW+VW-1:0] loc, size;
        logic             vis;
        logic [HW:0]      hh, x, w, xe;
        logic [VW:0]      vv, y, ht, ye;

        assign loc  = frame_start ? sh_loc_q[i]  : act_loc_q[i];
        assign size = frame_start ? sh_size_q[i] : act_size_q[i];
        assign vis  = frame_start ? sh_vis_q[i]  : act_vis_q[i];

        assign hh = {1'b0, h_cnt};
        assign vv = {1'b0, v_cnt};
        assign x  = {1'b0, loc[HW+VW-1:VW]};
        assign y  = {1'b0, loc[VW-1:0]};
        assign w  = {1'b0, size[HW+VW-1:VW]};
        assign ht = {1'b0, size[VW-1:0]};
        assign xe = x + w;
        assign ye = y + ht;

        assign hx_d[i] = vis && (w != '0) &&
                         ((hh >= x && hh < xe) || (xe > WrapW && hh < xe - WrapW));
        assign hy_d[i] = (ht != '0) && vv >= y && vv < ye;
    end

    always_comb begin
        hit_d     = pv1_q ? (hx_q & hy_q) : '0;
        top_idx_d = '0;
        for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
            if (hit_d[i]) top_idx_d = IW'(i);
        end
    end

    // Clear happens before set so a hit on the frame_start edge lands in the new frame.
    always_comb begin
        sticky_d = frame_start ? '0 : sticky_q;
        for (int i = 1; i < int'(N_OBJ); i++) begin
            if (out_valid_q && hit_q[0] && hit_q[i]) sticky_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hx_q         <= '0;
            hy_q         <= '0;
            pv1_q        <= 1'b0;
            hit_q        <= '0;
            top_hit_q    <= 1'b0;
            top_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            sticky_q     <= '0;
            coll_vec_q   <= '0;
            coll_valid_q <= 1'b0;
        end else begin
            hx_q         <= hx_d;
            hy_q         <= hy_d;
            pv1_q        <= pix_valid;
            hit_q        <= hit_d;
            top_hit_q    <= |hit_d;
            top_idx_q    <= top_idx_d;
            out_valid_q  <= pv1_q;
            sticky_q     <= sticky_d;
            coll_valid_q <= frame_start;
            if (frame_start) coll_vec_q <= {sticky_q, 1'b0};
        end
    end

    assign out_valid  = out_valid_q;
    assign hit_vec    = hit_q;
    assign top_hit    = top_hit_q;
    assign top_idx    = top_idx_q;
    assign coll_vec   = coll_vec_q;
    assign coll_valid = coll_valid_q;

endmodule

// File: tb/tb_sprite_hit_engine.sv
// Directed bench for sprite_hit_engine: table commit, hit rule, wrap, priority,
// collisions and mid-stream reset, checked with immediate assertions.
module tb_sprite_hit_engine;

    localparam int N_OBJ = 8;
    localparam int HW = 10;
    localparam int VW = 10;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_start = 1'b0;
    logic             pix_valid = 1'b0;
    logic [HW-1:0]    h_cnt = '0;
    logic [VW-1:0]    v_cnt = '0;
    logic             wr_en = 1'b0;
    logic [IW-1:0]    wr_idx = '0;
    logic [HW+VW-1:0] wr_loc = '0;
    logic [HW+VW-1:0] wr_size = '0;
    logic             wr_vis = 1'b0;
    logic             out_valid;
    logic [N_OBJ-1:0] hit_vec;
    logic             top_hit;
    logic [IW-1:0]    top_idx;
    logic [N_OBJ-1:0] coll_vec;
    logic             coll_valid;

    int n_vec = 0;
    int n_err = 0;

    sprite_hit_engine #(.N_OBJ(8), .HW(10), .VW(10), .WRAP_W(850)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_loc     (wr_loc),
        .wr_size    (wr_size),
        .wr_vis     (wr_vis),
        .out_valid  (out_valid),
        .hit_vec    (hit_vec),
        .top_hit    (top_hit),
        .top_idx    (top_idx),
        .coll_vec   (coll_vec),
        .coll_valid (coll_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a negedge.
    task automatic set_wr(input int idx, input int x, input int y, input int w, input int h,
                          input logic vis);
        wr_en   = 1'b1;
        wr_idx  = IW'(idx);
        wr_loc  = {HW'(x), VW'(y)};
        wr_size = {HW'(w), VW'(h)};
        wr_vis  = vis;
    endtask

    task automatic wr(input int idx, input int x, input int y, input int w, input int h,
                      input logic vis);
        set_wr(idx, x, y, w, h, vis);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pix(input string tag, input int h, input int v, input logic [7:0] exp_vec,
                       input int exp_idx);
        pix_valid = 1'b1;
        h_cnt = HW'(h);
        v_cnt = VW'(v);
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".ov"}, 32'(out_valid), 32'd1);
        chk({tag, ".vec"}, 32'(hit_vec), 32'(exp_vec));
        chk({tag, ".top"}, 32'(top_hit), 32'(|exp_vec));
        chk({tag, ".idx"}, 32'(top_idx), 32'(exp_idx));
    endtask

    task automatic chk_coll(input string tag, input logic [7:0] exp_vec, input logic exp_v);
        chk({tag, ".cv"}, 32'(coll_vec), 32'(exp_vec));
        chk({tag, ".cvalid"}, 32'(coll_valid), 32'(exp_v));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk("rst.vec", 32'(hit_vec), 32'd0);
        chk("rst.idx", 32'(top_idx), 32'd0);
        chk_coll("rst", 8'h00, 1'b0);

        // Basic hit and right-edge exclusion
        wr(2, 100, 50, 20, 10, 1'b1);
        commit();
        pix("t1a", 119, 55, 8'h04, 2);
        pix("t1b", 120, 55, 8'h00, 0);

        // Horizontal wrap at 850
        wr(1, 840, 0, 20, 5, 1'b1);
        commit();
        pix("t2_845", 845, 0, 8'h02, 1);
        pix("t2_849", 849, 0, 8'h02, 1);
        pix("t2_0", 0, 0, 8'h02, 1);
        pix("t2_9", 9, 4, 8'h02, 1);
        pix("t2_10", 10, 0, 8'h00, 0);
        pix("t2_839", 839, 0, 8'h00, 0);
        pix("t2_v5", 845, 5, 8'h00, 0);

        // Overlap and priority
        wr(3, 5, 5, 10, 10, 1'b1);
        wr(5, 10, 10, 1, 1, 1'b1);
        commit();
        pix("t3a", 10, 10, 8'h28, 3);
        wr(3, 5, 5, 10, 10, 1'b0);
        pix("t3_pre", 10, 10, 8'h28, 3);
        commit();
        pix("t3b", 10, 10, 8'h20, 5);

        // Double buffer
        wr(0, 10, 10, 1, 1, 1'b1);
        commit();
        pix("t4a", 10, 10, 8'h21, 0);
        wr(0, 300, 10, 1, 1, 1'b1);
        pix("t4b", 10, 10, 8'h21, 0);
        pix("t4c", 300, 10, 8'h00, 0);
        set_wr(0, 500, 10, 1, 1, 1'b1);
        commit();
        wr_en = 1'b0;
        pix("t4d", 300, 10, 8'h01, 0);
        pix("t4e", 500, 10, 8'h00, 0);
        commit();
        pix("t4f", 500, 10, 8'h01, 0);

        // Collisions: single-pixel overlap of slot 0 and slot 4 at (204,204)
        wr(0, 200, 200, 5, 5, 1'b1);
        wr(4, 204, 204, 5, 5, 1'b1);
        commit();
        pix("t5a", 204, 204, 8'h11, 0);
        pix("t5b", 203, 203, 8'h01, 0);
        commit();
        chk_coll("t5_f2", 8'h10, 1'b1);
        @(negedge clk);
        chk_coll("t5_f2p", 8'h10, 1'b0);
        // Stage-2 hit coincides with the frame_start edge: carried into the next frame
        pix("t5c", 204, 204, 8'h11, 0);
        commit();
        chk_coll("t5_f3", 8'h00, 1'b1);
        commit();
        chk_coll("t5_f4", 8'h10, 1'b1);
        commit();
        chk_coll("t5_f5", 8'h00, 1'b1);

        // Pixel coincident with frame_start uses the newly committed table
        wr(6, 600, 300, 2, 2, 1'b1);
        pix("t7_pre", 600, 300, 8'h00, 0);
        frame_start = 1'b1;
        pix("t7", 600, 300, 8'h40, 6);
        frame_start = 1'b0;
        pix("t7_w0", 601, 301, 8'h40, 6);
        pix("t7_w1", 602, 300, 8'h00, 0);

        // Reset mid-stream
        pix_valid = 1'b1;
        h_cnt = HW'(600);
        v_cnt = VW'(300);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6.ov0", 32'(out_valid), 32'd0);
        chk("t6.vec0", 32'(hit_vec), 32'd0);
        chk_coll("t6", 8'h00, 1'b0);
        @(negedge clk);
        chk("t6.ov1", 32'(out_valid), 32'd0);
        chk("t6.vec1", 32'(hit_vec), 32'd0);
        @(negedge clk);
        chk("t6.ov2", 32'(out_valid), 32'd1);
        chk("t6.vec2", 32'(hit_vec), 32'd0);
        pix_valid = 1'b0;
        @(negedge clk);
        commit();
        pix("t6_empty", 600, 300, 8'h00, 0);
        pix("t6_empty2", 119, 55, 8'h00, 0);
        wr(6, 600, 300, 2, 2, 1'b1);
        commit();
        pix("t6_back", 600, 300, 8'h40, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sprite_hit_engine.md
Name: sprite_hit_engine

Overview:
- Pipelined, parametrised pixel hit-test engine for the VGA sprite path.
- For each visible pixel it reports which of N objects (tubes, stars, TA, ...) cover it, including horizontal wrap-around at the world width.
- Also reports the highest-priority covering object and a per-frame sticky collision vector between object 0 (player) and every other object.
- Object table is double-buffered: written anytime, committed at frame start, so the picture never tears.

Parameters:
N_OBJ, 8, number of object slots (2..32)
HW, 10, width of h_cnt and of the x/width fields
VW, 10, width of v_cnt and of the y/height fields
WRAP_W, 850, horizontal world width; x coordinates wrap modulo WRAP_W
IW, $clog2(N_OBJ), index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse at h_cnt=0, v_cnt=0; commits table, closes collision frame
pix_valid  in  1  current h_cnt/v_cnt is a visible pixel
h_cnt  in  HW  pixel column
v_cnt  in  VW  pixel row
wr_en  in  1  shadow-table write strobe
wr_idx  in  IW  slot to write; writes with wr_idx >= N_OBJ are ignored
wr_loc  in  HW+VW  {x, y} top-left corner
wr_size  in  HW+VW  {w, h} extent
wr_vis  in  1  slot enable
out_valid  out  1  pix_valid delayed 2 cycles
hit_vec  out  N_OBJ  bit i = object i covers the pixel
top_hit  out  1  OR of hit_vec
top_idx  out  IW  lowest set index in hit_vec; 0 when none
coll_vec  out  N_OBJ  previous frame's collisions; bit 0 always 0
coll_valid  out  1  one-cycle pulse when coll_vec updates

Behaviour:
Reset:
- Shadow and active tables clear: loc, size and vis all 0.
- All outputs and pipeline registers go to 0.
- Reset mid-frame discards in-flight pixels. No out_valid until 2 cycles after the next pix_valid.

Table:
- wr_en writes slot wr_idx of the shadow table on the clock edge.
- On frame_start, active table <= shadow table as it was before that edge. A write in the same cycle lands in shadow only and is visible from the following frame.
- The hit test uses the active table only.

Hit rule, per slot i, with x/y/w/h taken from active loc/size:
- Arithmetic is done at HW+1 / VW+1 bits; there is no truncation.
- hx = (h >= x && h < x+w) || (x+w > WRAP_W && h < x+w-WRAP_W).
- hy = (v >= y && v < y+h). There is no vertical wrap.
- hit_i = vis_i && hx && hy.
- w=0 or h=0 never hits.
- x >= WRAP_W is legal; the first term still applies and the wrap term uses the same formula.

Pipeline (fixed latency 2):
- Stage 1 registers the hx/hy compare vectors and pix_valid.
- Stage 2 registers hit_vec, top_hit, top_idx and out_valid.
- When out_valid=0, hit_vec, top_hit and top_idx are forced to 0.
- Throughput: one pixel per clock, no stalls.

Collision:
- Sticky register S[N_OBJ-1:1].
- When stage-2 pixel is valid and hit_vec[0] && hit_vec[i], set S[i].
- On frame_start: coll_vec <= {S,0}, coll_valid pulses next cycle, S clears.
- A stage-2 hit in the same cycle as frame_start is recorded into the new S (clear then set); it is not lost.

Simultaneous frame_start and pix_valid:
- Legal. The pixel is tested against the newly committed table.

Test Plan:
1. Slot 2 = {x=100, y=50}, {w=20, h=10}, vis=1, then frame_start; scan (119,55) and (120,55) -> 2 cycles later hit_vec=0x04, top_idx=2, then hit_vec=0x00, top_hit=0.
2. Wrap: slot 1 x=840, w=20, y=0, h=5 -> hit at h=845, h=849, h=0, h=9; no hit at h=10 or h=839; no hit at v=5.
3. Priority/overlap: slots 3 and 5 both cover (10,10) -> hit_vec=0x28, top_idx=3; clear vis of 3 via write plus frame_start -> top_idx=5 next frame.
4. Double-buffer: rewrite slot 0 mid-frame to x=300 -> current frame still uses the old x. A write coincident with frame_start is not active until the following frame_start.
5. Collision: slot 0 overlaps slot 4 on one pixel only; next frame_start -> coll_valid pulse, coll_vec=0x10. The frame after that, with no overlap -> coll_vec=0x00.
6. Reset mid-stream: assert rst for 1 cycle while pix_valid=1 -> out_valid=0 and hit_vec=0 for 2 cycles; table reads back empty (no hits) until rewritten and committed.
